// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hazard stall, flush-to-bubble.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry that cuts the out_ready -> in_ready path.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH  = 64,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] main_q, main_nxt;
   logic             in_fire;
   logic             out_fire;

   assign out_valid = (state != EMPTY);
   assign out_data  = out_valid ? main_q : BUBBLE;
   assign count_o   = state;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready & ~stall_i & ~flush_i;

`ifdef PIPE_STAGE_REG_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_nxt;

   // The skid entry absorbs the word in flight, so out_ready never reaches in_ready.
   assign in_ready = ~rst & ~stall_i & ~flush_i & (state != FULL);

   always_comb begin
      // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush_i) begin
         state_nxt = EMPTY;
         main_nxt  = BUBBLE;
         skid_nxt  = BUBBLE;
      end else if (!stall_i) begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = ONE;
                  main_nxt  = in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire) begin
                  state_nxt = FULL;
                  skid_nxt  = in_data;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) skid_q <= BUBBLE;
      else     skid_q <= skid_nxt;
   end
`else
   // Single entry: a held word can only be replaced when it leaves this same cycle.
   assign in_ready = ~rst & ~stall_i & ~flush_i & (~out_valid | out_ready);

   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      if (flush_i) begin
         state_nxt = EMPTY;
         main_nxt  = BUBBLE;
      end else if (!stall_i) begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = ONE;
                  main_nxt  = in_data;
               end
            end
            ONE: begin
               if (in_fire) begin
                  main_nxt = in_data;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments on all state so every register samples pre-edge values.
      if (rst) begin
         state  <= EMPTY;
         // NOTE: the payload is reset too, so a dropped stream never leaves stale data behind.
         main_q <= BUBBLE;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
      end
   end

endmodule
